// File: rtl/iodelay_cal_pkg.sv
// Shared types and constants for the IDELAY tap calibration block.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package iodelay_cal_pkg;

  // IDELAYE2 exposes 32 taps, so a tap index is 5 bits wide.
  localparam int tap_w_c = 5;
  // Window lengths reach 32, which needs one more bit than a tap index.
  localparam int win_w_c = 6;
  localparam logic [tap_w_c-1:0] last_tap_c = 5'd31;

  typedef enum logic [2:0] {
    WAIT_RDY,
    LOAD,
    SETTLE,
    SAMPLE,
    EVAL,
    FINAL_LOAD,
    FINAL_SETTLE,
    DONE
  } cal_state_e;

  // Centre of a passing window, rounding toward the lower tap.
  // An empty window parks the delay line at tap 0.
  function automatic logic [tap_w_c-1:0] center_tap(
    input logic [tap_w_c-1:0] start,
    input logic [win_w_c-1:0] len
  );
    logic [win_w_c-1:0] half;
    logic [win_w_c-1:0] sum;
    if (len == '0) begin
      return '0;
    end
    half = (len - 6'd1) >> 1;
    sum  = {1'b0, start} + half;
    return sum[tap_w_c-1:0];
  endfunction

endpackage

// File: rtl/iodelay_tap_cal_if.sv
// Bundles the IDELAY control, training data and calibration result signals.
// Latency: n/a (wiring only).
// Backpressure: none; the tap load is a fire-and-forget strobe.
interface iodelay_tap_cal_if #(
  parameter int data_width_p = 8
);
  import iodelay_cal_pkg::*;

  logic                    rdy;
  logic [data_width_p-1:0] data;
  logic                    idelay_ld;
  logic [tap_w_c-1:0]      cnt_value;
  logic                    done;
  logic                    fail;
  logic [win_w_c-1:0]      win_len;

  // Environment side: supplies RDY and the captured word, observes results.
  modport master (
    output rdy,
    output data,
    input  idelay_ld,
    input  cnt_value,
    input  done,
    input  fail,
    input  win_len
  );

  // Calibrator side.
  modport slave (
    input  rdy,
    input  data,
    output idelay_ld,
    output cnt_value,
    output done,
    output fail,
    output win_len
  );

endinterface

// File: rtl/bsg_sync_sync.sv
// Two-flop synchronizer bringing a level into the destination clock domain.
// Latency: 2 destination clock cycles.
// Backpressure: none; the level is sampled continuously.
module bsg_sync_sync #(
  parameter int width_p = 1
) (
  input  logic               oclk_i,
  input  logic               oclk_reset_i,
  input  logic [width_p-1:0] iclk_data_i,
  output logic [width_p-1:0] oclk_data_o
);

  logic [width_p-1:0] sync1_r;
  logic [width_p-1:0] sync2_r;

  // First flop may go metastable; second flop gives it a cycle to resolve.
  always_ff @(posedge oclk_i) begin
    if (oclk_reset_i) begin
      sync1_r <= '0;
      sync2_r <= '0;
    end else begin
      sync1_r <= iclk_data_i;
      sync2_r <= sync1_r;
    end
  end

  assign oclk_data_o = sync2_r;

endmodule

// File: rtl/iodelay_tap_cal.sv
// Sweeps all 32 IDELAY taps, finds the widest passing window and parks at its centre.
// Latency: 32 x (settle + samples + 2) cycles for the sweep plus settle + 1 to done.
// Backpressure: none; loss of IDELAYCTRL RDY aborts and restarts the calibration.
module iodelay_tap_cal
  import iodelay_cal_pkg::*;
#(
  parameter int                    data_width_p    = 8,
  parameter logic [data_width_p-1:0] pattern_p     = data_width_p'(8'hA5),
  parameter int                    settle_cycles_p = 16,
  parameter int                    samples_p       = 8
) (
  input  logic               iodelay_ref_clk_lo,
  input  logic               reset_r_i,
  iodelay_tap_cal_if.slave   cal_if
);

  localparam logic [7:0] settle_last_c = 8'(settle_cycles_p - 1);
  localparam logic [7:0] sample_last_c = 8'(samples_p - 1);

  cal_state_e          state_r;
  logic                rdy_s;
  logic [tap_w_c-1:0]  tap_r;
  logic [7:0]          phase_cnt_r;
  logic                tap_ok_r;
  logic [win_w_c-1:0]  run_len_r;
  logic [tap_w_c-1:0]  run_start_r;
  logic [win_w_c-1:0]  best_len_r;
  logic [tap_w_c-1:0]  best_start_r;
  logic                idelay_ld_r;
  logic [tap_w_c-1:0]  cnt_value_r;
  logic                done_r;
  logic                fail_r;
  logic [win_w_c-1:0]  win_len_r;

  logic [win_w_c-1:0]  run_len_nxt;
  logic [tap_w_c-1:0]  run_start_nxt;
  logic [win_w_c-1:0]  best_len_nxt;
  logic [tap_w_c-1:0]  best_start_nxt;
  logic                match;

  bsg_sync_sync #(
    .width_p (1)
  ) rdy_sync (
    .oclk_i       (iodelay_ref_clk_lo),
    .oclk_reset_i (reset_r_i),
    .iclk_data_i  (cal_if.rdy),
    .oclk_data_o  (rdy_s)
  );

  assign match = (cal_if.data == pattern_p);

  // Run/best-window bookkeeping for the tap just sampled. Best is updated as
  // soon as the running window outgrows it, so a run touching tap 31 is
  // accounted without a separate close step; strict '>' keeps the earliest tie.
  always_comb begin
    run_len_nxt    = '0;
    run_start_nxt  = run_start_r;
    best_len_nxt   = best_len_r;
    best_start_nxt = best_start_r;
    if (tap_ok_r) begin
      run_len_nxt = run_len_r + 6'd1;
      if (run_len_r == '0) begin
        run_start_nxt = tap_r;
      end
      if (run_len_nxt > best_len_r) begin
        best_len_nxt   = run_len_nxt;
        best_start_nxt = run_start_nxt;
      end
    end
  end

  // Calibration sequencer; all outputs are registered here.
  always_ff @(posedge iodelay_ref_clk_lo) begin
    if (reset_r_i || (!rdy_s && (state_r != WAIT_RDY))) begin
      state_r      <= WAIT_RDY;
      tap_r        <= '0;
      phase_cnt_r  <= '0;
      tap_ok_r     <= 1'b0;
      run_len_r    <= '0;
      run_start_r  <= '0;
      best_len_r   <= '0;
      best_start_r <= '0;
      idelay_ld_r  <= 1'b0;
      cnt_value_r  <= '0;
      done_r       <= 1'b0;
      fail_r       <= 1'b0;
      win_len_r    <= '0;
    end else begin
      case (state_r)
        WAIT_RDY: begin
          if (rdy_s) begin
            state_r     <= LOAD;
            idelay_ld_r <= 1'b1;
            cnt_value_r <= tap_r;
          end
        end
        LOAD: begin
          idelay_ld_r <= 1'b0;
          phase_cnt_r <= '0;
          state_r     <= SETTLE;
        end
        SETTLE: begin
          if (phase_cnt_r == settle_last_c) begin
            phase_cnt_r <= '0;
            tap_ok_r    <= 1'b1;
            state_r     <= SAMPLE;
          end else begin
            phase_cnt_r <= phase_cnt_r + 8'd1;
          end
        end
        SAMPLE: begin
          tap_ok_r <= tap_ok_r & match;
          if (phase_cnt_r == sample_last_c) begin
            phase_cnt_r <= '0;
            state_r     <= EVAL;
          end else begin
            phase_cnt_r <= phase_cnt_r + 8'd1;
          end
        end
        EVAL: begin
          run_len_r    <= run_len_nxt;
          run_start_r  <= run_start_nxt;
          best_len_r   <= best_len_nxt;
          best_start_r <= best_start_nxt;
          idelay_ld_r  <= 1'b1;
          if (tap_r == last_tap_c) begin
            state_r     <= FINAL_LOAD;
            cnt_value_r <= center_tap(best_start_nxt, best_len_nxt);
          end else begin
            state_r     <= LOAD;
            tap_r       <= tap_r + 5'd1;
            cnt_value_r <= tap_r + 5'd1;
          end
        end
        FINAL_LOAD: begin
          idelay_ld_r <= 1'b0;
          phase_cnt_r <= '0;
          state_r     <= FINAL_SETTLE;
        end
        FINAL_SETTLE: begin
          if (phase_cnt_r == settle_last_c) begin
            phase_cnt_r <= '0;
            done_r      <= 1'b1;
            fail_r      <= (best_len_r == '0);
            win_len_r   <= best_len_r;
            state_r     <= DONE;
          end else begin
            phase_cnt_r <= phase_cnt_r + 8'd1;
          end
        end
        DONE: begin
          idelay_ld_r <= 1'b0;
        end
        default: begin
          state_r <= WAIT_RDY;
        end
      endcase
    end
  end

  assign cal_if.idelay_ld = idelay_ld_r;
  assign cal_if.cnt_value = cnt_value_r;
  assign cal_if.done      = done_r;
  assign cal_if.fail      = fail_r;
  assign cal_if.win_len   = win_len_r;

endmodule

// File: tb/tb_iodelay_tap_cal.sv
// Directed bench for the IDELAY tap calibrator with a tap-dependent pattern source.
// Latency: n/a.
// Backpressure: n/a.
module tb_iodelay_tap_cal;

  localparam logic [7:0] pat_c = 8'hA5;

  logic clk;
  logic rst;

  iodelay_tap_cal_if #(.data_width_p(8)) ifc ();

  iodelay_tap_cal #(
    .data_width_p    (8),
    .pattern_p       (pat_c),
    .settle_cycles_p (16),
    .samples_p       (8)
  ) dut (
    .iodelay_ref_clk_lo (clk),
    .reset_r_i          (rst),
    .cal_if             (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Pattern source state: which taps return the training word.
  logic [31:0] pass_mask = '0;
  bit          glitch_en = 1'b0;
  logic [4:0]  cur_tap   = '0;
  int          off       = 0;
  int          cyc       = 0;
  int          ld_cnt    = 0;
  int          ld_last   = 0;
  int          gap_bad   = 0;
  int          ld_wide   = 0;
  int          done_cyc  = 0;
  bit          prev_ld   = 1'b0;
  bit          prev_done = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Emulates the delay line: each tap returns the pattern or its complement,
  // with an optional single bad sample on the last sample of tap 31.
  initial begin
    ifc.data = ~pat_c;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (ifc.idelay_ld) begin
        if (prev_ld) ld_wide++;
        if (ld_cnt > 0 && (cyc - ld_last) != 26) gap_bad++;
        ld_cnt++;
        ld_last = cyc;
        cur_tap = ifc.cnt_value;
        off     = 0;
      end else begin
        off++;
      end
      if (ifc.done && !prev_done) done_cyc = cyc;
      prev_ld   = ifc.idelay_ld;
      prev_done = ifc.done;
      ifc.data = (pass_mask[cur_tap] && !(glitch_en && cur_tap == 5'd31 && off == 24)) ? pat_c : ~pat_c;
    end
  end

  task automatic start_cal(input logic [31:0] mask, input bit glitch);
    @(posedge clk);
    #2;
    pass_mask = mask;
    glitch_en = glitch;
    rst       = 1'b1;
    ifc.rdy   = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    ld_cnt = 0; gap_bad = 0; ld_wide = 0; done_cyc = 0; ld_last = 0;
    rst = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int k;
    k = 0;
    while (!ifc.done && k < 2000) begin
      @(posedge clk);
      #2;
      k++;
    end
    chk({tag, "_done"}, ifc.done, 1);
  endtask

  initial begin
    int k;
    int snap;
    rst       = 1'b1;
    ifc.rdy   = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_ld",   ifc.idelay_ld, 0);
    chk("rst_cnt",  ifc.cnt_value, 0);
    chk("rst_done", ifc.done, 0);
    chk("rst_fail", ifc.fail, 0);
    chk("rst_win",  ifc.win_len, 0);

    // Window 10..20: centre 15, length 11, plus strobe timing.
    start_cal(32'h001F_FC00, 1'b0);
    wait_done("w10_20");
    chk("w10_20_fail",  ifc.fail, 0);
    chk("w10_20_tap",   ifc.cnt_value, 15);
    chk("w10_20_win",   ifc.win_len, 11);
    chk("w10_20_nld",   ld_cnt, 33);
    chk("w10_20_gap",   gap_bad, 0);
    chk("w10_20_wide",  ld_wide, 0);
    chk("w10_20_dly",   done_cyc - ld_last, 17);

    // Two equal windows 2..5 and 20..23: earliest wins.
    start_cal(32'h00F0_003C, 1'b0);
    wait_done("tie");
    chk("tie_fail", ifc.fail, 0);
    chk("tie_tap",  ifc.cnt_value, 3);
    chk("tie_win",  ifc.win_len, 4);

    // No passing tap.
    start_cal(32'h0000_0000, 1'b0);
    wait_done("none");
    chk("none_fail", ifc.fail, 1);
    chk("none_tap",  ifc.cnt_value, 0);
    chk("none_win",  ifc.win_len, 0);

    // Every tap passes.
    start_cal(32'hFFFF_FFFF, 1'b0);
    wait_done("all");
    chk("all_fail", ifc.fail, 0);
    chk("all_tap",  ifc.cnt_value, 15);
    chk("all_win",  ifc.win_len, 32);

    // Every tap passes except one bad sample late in tap 31.
    start_cal(32'hFFFF_FFFF, 1'b1);
    wait_done("glitch");
    chk("glitch_tap", ifc.cnt_value, 15);
    chk("glitch_win", ifc.win_len, 31);

    // RDY loss while sampling tap 12, then recovery.
    start_cal(32'h001F_FC00, 1'b0);
    k = 0;
    while (!(cur_tap == 5'd12 && off == 18) && k < 2000) begin
      @(posedge clk);
      #2;
      k++;
    end
    chk("drop_reach", cur_tap, 12);
    ifc.rdy = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("drop_cnt",  ifc.cnt_value, 0);
    chk("drop_ld",   ifc.idelay_ld, 0);
    chk("drop_done", ifc.done, 0);
    snap = ld_cnt;
    repeat (10) @(posedge clk);
    #2;
    chk("drop_quiet", ld_cnt, snap);
    ifc.rdy = 1'b1;
    k = 0;
    while (!ifc.idelay_ld && k < 10) begin
      @(posedge clk);
      #2;
      k++;
    end
    chk("restart_ld",  ifc.idelay_ld, 1);
    chk("restart_tap", ifc.cnt_value, 0);
    wait_done("restart");
    chk("restart_fin", ifc.cnt_value, 15);
    chk("restart_win", ifc.win_len, 11);

    // Reset in the middle of a sweep: no strobe while held.
    start_cal(32'hFFFF_FFFF, 1'b0);
    k = 0;
    while (!(cur_tap == 5'd5 && off == 5) && k < 2000) begin
      @(posedge clk);
      #2;
      k++;
    end
    chk("midrst_reach", cur_tap, 5);
    rst  = 1'b1;
    snap = ld_cnt;
    repeat (40) @(posedge clk);
    #2;
    chk("midrst_quiet", ld_cnt, snap);
    chk("midrst_cnt",   ifc.cnt_value, 0);
    chk("midrst_done",  ifc.done, 0);
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/iodelay_tap_cal.md
IODELAY_TAP_CAL -- requirements
Module: iodelay_tap_cal

Interface
REQ-001: Parameter data_width_p, default 8, width of sampled input bus.
REQ-002: Parameter pattern_p, default 8'hA5, expected training word (data_width_p bits).
REQ-003: Parameter settle_cycles_p, default 16, wait cycles after each tap load (1..255).
REQ-004: Parameter samples_p, default 8, consecutive compares per tap (1..255).
REQ-005: clk_i  input  1  sole clock; the IDELAY control clock.
REQ-006: reset_i  input  1  reset, synchronous and active-high.
REQ-007: rdy_i  input  1  IDELAYCTRL RDY, asynchronous to clk_i.
REQ-008: data_i  input  data_width_p  word captured through the IDELAY under calibration.
REQ-009: idelay_ld_o  output  1  one-cycle load strobe to IDELAYE2 (VAR_LOAD mode).
REQ-010: cnt_value_o  output  5  tap value presented with idelay_ld_o.
REQ-011: done_o  output  1  calibration finished, final tap loaded and settled.
REQ-012: fail_o  output  1  no passing tap found; valid only when done_o=1.
REQ-013: win_len_o  output  6  length of selected passing window (0..32).

Function
REQ-014: rdy_i SHALL pass through a 2-flop synchronizer; rdy_s is its output.
REQ-015: States: WAIT_RDY, LOAD, SETTLE, SAMPLE, EVAL, FINAL_LOAD, FINAL_SETTLE, DONE.
REQ-016: WAIT_RDY -> LOAD when rdy_s=1; sweep tap counter starts at 0.
REQ-017: LOAD SHALL assert idelay_ld_o for exactly one cycle with cnt_value_o=current tap, then -> SETTLE.
REQ-018: SETTLE SHALL last exactly settle_cycles_p cycles, then -> SAMPLE.
REQ-019: SAMPLE SHALL compare data_i to pattern_p on each of samples_p consecutive cycles; tap passes only if all compares match.
REQ-020: EVAL (one cycle) SHALL update run tracking: pass extends current run (start recorded on first pass); fail closes run.
REQ-021: Best window = longest contiguous passing run; ties keep the earliest (lowest start tap); a run reaching tap 31 closes at end of sweep.
REQ-022: EVAL -> LOAD with tap+1 if tap<31; tap=31 -> FINAL_LOAD; no wrap-around of the tap counter.
REQ-023: Final tap = best_start + floor((best_len-1)/2); if best_len=0, final tap=0 and fail_o=1.
REQ-024: FINAL_LOAD pulses idelay_ld_o one cycle with final tap; FINAL_SETTLE waits settle_cycles_p; then DONE.
REQ-025: DONE SHALL hold done_o=1, cnt_value_o=final tap, win_len_o=best_len, fail_o per REQ-023, until reset or rdy loss.
REQ-026: rdy_s falling in any state other than WAIT_RDY SHALL, next cycle, return to WAIT_RDY and clear tap, run, best, done_o, fail_o, win_len_o (full recalibration).
REQ-027: idelay_ld_o SHALL never assert outside LOAD/FINAL_LOAD.
REQ-028: Window lengths use 6-bit arithmetic; all-32-pass yields win_len_o=32, final tap 15.

Reset
REQ-029: On reset_i=1: state WAIT_RDY, synchronizer flops 0, idelay_ld_o=0, cnt_value_o=0, done_o=0, fail_o=0, win_len_o=0, all counters 0.
REQ-030: reset_i asserted mid-sweep SHALL abort with no further load strobe after the reset edge.

Structure
REQ-031: State enum and tap width constant (5) SHALL live in shared package iodelay_cal_pkg.
REQ-032: The rdy_i synchronizer SHALL be one instance of bsg_sync_sync; remaining logic flat.

Verification
REQ-033: Passing taps 10..20 only, defaults -> 32 load pulses in sweep, final cnt_value_o=15, win_len_o=11, fail_o=0.
REQ-034: Two windows 2..5 and 20..23 -> tie, final tap 3, win_len_o=4.
REQ-035: No tap passes -> done_o=1, fail_o=1, cnt_value_o=0, win_len_o=0.
REQ-036: All taps pass -> final tap 15, win_len_o=32; single mismatch at sample 7 of tap 31 -> win_len_o=31, final tap 15.
REQ-037: Drop rdy_i during SAMPLE of tap 12 -> returns to WAIT_RDY within 3 cycles, outputs cleared; reassert -> sweep restarts at tap 0.
REQ-038: Timing check, defaults: load pulses exactly 1+16+8+1=26 cycles apart; done_o rises 17 cycles after final load pulse.
